mod5_serial_tx: RTL and testbench



---
 rtl/mod5_pkg.sv | 40 ++++
 rtl/mod5_serial_tx.sv | 97 +++++++++
 tb/tb_mod5_serial_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mod5_pkg.sv
// ============================================================================
// Module      : mod5_pkg
// Description : Shared types and residue-update table for the mod-5 serial link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod5_pkg;

  typedef enum logic [2:0] {
    REM_0 = 3'd0,
    REM_1 = 3'd1,
    REM_2 = 3'd2,
    REM_3 = 3'd3,
    REM_4 = 3'd4
  } residue_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  // Appending bit b to a value with residue r gives residue (2r + b) mod 5.
  function automatic residue_t mod5_next(input residue_t r, input logic b);
    residue_t n;
    case (r)
      REM_0:   n = b ? REM_1 : REM_0;
      REM_1:   n = b ? REM_3 : REM_2;
      REM_2:   n = b ? REM_0 : REM_4;
      REM_3:   n = b ? REM_2 : REM_1;
      REM_4:   n = b ? REM_4 : REM_3;
      default: n = REM_0;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod5_serial_tx.sv
// ============================================================================
// Module      : mod5_serial_tx
// Description : MSB-first serialiser with frame markers and a running mod-5
//               residue used as the golden divisibility result for the link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod5_serial_tx
  import mod5_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o,
  output logic [2:0]       residue_o,
  output logic             divisible_o
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       c_ST_IDLE  = IDLE;
  localparam logic [1:0]       c_ST_SHIFT = SHIFT;
  localparam logic [1:0]       c_ST_DONE  = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  residue_t         r_residue;

  logic w_idle;
  logic w_shifting;
  logic w_done;
  logic w_bit;

  assign w_idle     = (r_state == c_ST_IDLE);
  assign w_shifting = (r_state == c_ST_SHIFT);
  assign w_done     = (r_state == c_ST_DONE);
  assign w_bit      = r_shift[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_residue <= REM_0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (valid_i) begin
            r_shift   <= data_i;
            r_cnt     <= c_CNT_MAX;
            r_residue <= REM_0;
            r_state   <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt - c_CNT_ONE;
          r_residue <= mod5_next(r_residue, w_bit);
          if (r_cnt == '0) begin
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registers so an async reset clears them at once.
  assign ready_o        = w_idle;
  assign serial_valid_o = w_shifting;
  assign serial_o       = w_shifting & w_bit;
  assign first_o        = w_shifting & (r_cnt == c_CNT_MAX);
  assign last_o         = w_shifting & (r_cnt == '0);
  assign done_o         = w_done;
  assign residue_o      = r_residue;
  assign divisible_o    = w_done & (r_residue == REM_0);

endmodule

`default_nettype wire

// File: tb/tb_mod5_serial_tx.sv
// ============================================================================
// Module      : tb_mod5_serial_tx
// Description : Self-checking bench for mod5_serial_tx (WIDTH=8 and WIDTH=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod5_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, ser, sval, first, last, done, div;
  logic [2:0] res;

  logic [4:0] data5;
  logic       valid5;
  logic       ready5, ser5, sval5, first5, last5, done5, div5;
  logic [2:0] res5;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc[$];

  typedef struct {
    logic [7:0] d;
    logic [2:0] exp_res;
    logic       exp_div;
  } vec_t;

  vec_t vecs[4];

  mod5_serial_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data), .valid_i(valid), .ready_o(ready),
    .serial_o(ser), .serial_valid_o(sval), .first_o(first), .last_o(last),
    .done_o(done), .residue_o(res), .divisible_o(div)
  );

  mod5_serial_tx #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .data_i(data5), .valid_i(valid5), .ready_o(ready5),
    .serial_o(ser5), .serial_valid_o(sval5), .first_o(first5), .last_o(last5),
    .done_o(done5), .residue_o(res5), .divisible_o(div5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (ready && valid) acc_cyc.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after done.
  task automatic run_frame8(input logic [7:0] d, input logic [2:0] exp_res,
                            input logic exp_div, input string tag);
    int r = 0;
    check({tag, "_ready"}, 32'(ready), 1);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      check($sformatf("%s_sval%0d", tag, k), 32'(sval), 1);
      check($sformatf("%s_ser%0d", tag, k), 32'(ser), 32'(d[k]));
      check($sformatf("%s_first%0d", tag, k), 32'(first), 32'(k == 7));
      check($sformatf("%s_last%0d", tag, k), 32'(last), 32'(k == 0));
      check($sformatf("%s_res%0d", tag, k), 32'(res), 32'(r));
      check($sformatf("%s_nrdy%0d", tag, k), 32'(ready), 0);
      r = (2 * r + int'(d[k])) % 5;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_fres"}, 32'(res), 32'(exp_res));
    check({tag, "_div"}, 32'(div), 32'(exp_div));
    check({tag, "_sval_off"}, 32'(sval), 0);
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done), 0);
    check({tag, "_ready_back"}, 32'(ready), 1);
    check({tag, "_res_hold"}, 32'(res), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] wa;
    logic [4:0] w5;
    int lowcnt;

    vecs[0] = '{d: 8'h05, exp_res: 3'd0, exp_div: 1'b1};
    vecs[1] = '{d: 8'h0B, exp_res: 3'd1, exp_div: 1'b0};
    vecs[2] = '{d: 8'hFF, exp_res: 3'd0, exp_div: 1'b1};
    vecs[3] = '{d: 8'hFE, exp_res: 3'd4, exp_div: 1'b0};

    rst_n = 1'b1; data = '0; valid = 1'b0; data5 = '0; valid5 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_ser", 32'(ser), 0);
    check("rst_sval", 32'(sval), 0);
    check("rst_first", 32'(first), 0);
    check("rst_last", 32'(last), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res", 32'(res), 0);
    check("rst_div", 32'(div), 0);
    check("rst5_ready", 32'(ready5), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame8(vecs[i].d, vecs[i].exp_res, vecs[i].exp_div, $sformatf("v%0d", i));
    end

    // Back-to-back with valid held; data changes mid-frame must not leak.
    w0 = 8'h0A; w1 = 8'h07; lowcnt = 0;
    data = w0; valid = 1'b1;
    @(negedge clk);
    data = w1;
    for (int k = 7; k >= 0; k--) begin
      check($sformatf("b2b0_ser%0d", k), 32'(ser), 32'(w0[k]));
      if (!ready) lowcnt++;
      @(negedge clk);
    end
    if (!ready) lowcnt++;
    check("b2b0_done", 32'(done), 1);
    check("b2b0_div", 32'(div), 1);
    @(negedge clk);
    check("b2b_ready_again", 32'(ready), 1);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      check($sformatf("b2b1_ser%0d", k), 32'(ser), 32'(w1[k]));
      @(negedge clk);
    end
    check("b2b1_done", 32'(done), 1);
    check("b2b1_res", 32'(res), 2);
    check("b2b1_div", 32'(div), 0);
    check("b2b_ready_low", 32'(lowcnt), 9);
    check("b2b_accepts", 32'(acc_cyc.size() >= 2), 1);
    if (acc_cyc.size() >= 2)
      check("b2b_spacing", 32'(acc_cyc[$] - acc_cyc[$-1]), 10);
    @(negedge clk);

    // Reset mid-frame after three bits of 8'hA5.
    wa = 8'hA5;
    data = wa; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 7; k >= 5; k--) begin
      check($sformatf("rstf_ser%0d", k), 32'(ser), 32'(wa[k]));
      if (k > 5) @(negedge clk);
    end
    check("rstf_pre_res", 32'(res), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_sval", 32'(sval), 0);
    check("rstf_ser", 32'(ser), 0);
    check("rstf_res", 32'(res), 0);
    check("rstf_ready", 32'(ready), 1);
    check("rstf_first", 32'(first), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstf_nodone%0d", i), 32'(done), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("rstf_post_nodone%0d", i), 32'(done), 0);
    end
    check("rstf_post_ready", 32'(ready), 1);
    run_frame8(8'h14, 3'd0, 1'b1, "after_rst");

    // WIDTH=5 instance: 30 = 5'b11110.
    w5 = 5'b11110;
    data5 = w5; valid5 = 1'b1;
    @(negedge clk);
    valid5 = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      check($sformatf("w5_sval%0d", k), 32'(sval5), 1);
      check($sformatf("w5_ser%0d", k), 32'(ser5), 32'(w5[k]));
      check($sformatf("w5_first%0d", k), 32'(first5), 32'(k == 4));
      check($sformatf("w5_last%0d", k), 32'(last5), 32'(k == 0));
      @(negedge clk);
    end
    check("w5_done", 32'(done5), 1);
    check("w5_res", 32'(res5), 0);
    check("w5_div", 32'(div5), 1);
    @(negedge clk);
    check("w5_ready", 32'(ready5), 1);
    check("w5_done_off", 32'(done5), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
